matrix_mul_ctrl: RTL and testbench
==================================

// Module: matrix_mul_ctrl
// PURPOSE
//  Memory-mapped sequencer for the 8x8 32-bit matrix_mul datapath in the sigma SoC.
//  Host writes A and B into local buffers, then sets GO. The block clears the datapath,
//  holds start until done plus a drain period, and captures C into a readable buffer.
//  Status, sticky errors and an optional IRQ are reported to the host.
// PARAMETERS
//  DIM          8   matrix dimension; buffers hold DIM*DIM words
//  DRAIN_CYCLES 2   cycles start stays high after mm_done, before C is captured
//  TIMEOUT      64  max RUN cycles waiting for mm_done before aborting
// PORTS
//  clk       in   1      clock; single clock domain
//  reset     in   1      synchronous, active-high reset
//  host_req  in   1      host access request (1-cycle pulse per access)
//  host_we   in   1      1 = write, 0 = read
//  host_addr in   10     byte address; bits [1:0] ignored
//  host_wdata in  32     write data
//  host_ack  out  1      1-cycle acknowledge, the cycle after host_req
//  host_rdata out 32     read data, valid with host_ack
//  irq       out  1      level; high while STATUS.done=1 and CTRL.irq_en=1
//  mm_A/mm_B out  32x64  operand arrays to datapath, driven from A/B buffers
//  mm_C      in   32x64  result array from datapath
//  mm_start  out  1      datapath start/advance enable
//  mm_clear  out  1      datapath clear pulse
//  mm_done   in   1      datapath done flag
// BEHAVIOUR
//  Reset: FSM=IDLE. host_ack, host_rdata, irq, mm_start, mm_clear, CTRL, STATUS and
//   counters are 0. The A, B and C buffers are cleared to 0.
//  Address map: 0x000-0x0FC A[0..63] RW. 0x100-0x1FC B[0..63] RW.
//   0x200-0x2FC C[0..63] RO. 0x300 CTRL: bit0 go (write-only, reads 0), bit1 irq_en.
//   0x304 STATUS: bit0 busy, bit1 done, bit2 timeout, bit3 wr_err.
//   STATUS bits 1-3 are cleared by writing 1 to them.
//   Unmapped reads return 0. Unmapped writes are dropped and set wr_err.
//  Host access: every host_req is acked exactly one cycle later; no wait states.
//   A back-to-back req every cycle is legal.
//  FSM:
//   IDLE  -> CLEAR on a GO write when busy=0. The same GO write clears done and timeout.
//   CLEAR -> RUN after 1 cycle; mm_clear=1, mm_start=0.
//   RUN   -> mm_start=1, cycle counter increments from 0.
//            mm_done=1 -> DRAIN.
//            counter reaches TIMEOUT-1 without mm_done -> IDLE; set timeout, mm_start=0.
//   DRAIN -> mm_start=1 for DRAIN_CYCLES cycles -> CAPTURE.
//   CAPTURE -> IDLE after 1 cycle: C buffer <= mm_C (all 64 words), set done, mm_start=0.
//  busy=1 in CLEAR, RUN, DRAIN and CAPTURE.
//  mm_A and mm_B are driven combinationally from the A/B buffers and are stable while busy.
//  While busy:
//   A/B writes are dropped and set wr_err.
//   GO writes are ignored (no error).
//   C reads return the previous capture.
//  Simultaneous W1C of done and a CAPTURE-cycle set: set wins.
//  Reset mid-run: FSM returns to IDLE next cycle, mm_start drops to 0, no capture occurs.
//   The datapath is recleared by the CLEAR state of the next run.
//  Run latency: GO ack to done=1 is 1 + N_run + DRAIN_CYCLES + 1 cycles,
//   where N_run is the number of RUN cycles until mm_done is seen.
// STRUCTURE
//  matrix_mul_ctrl_pkg:
//   state enum {IDLE, CLEAR, RUN, DRAIN, CAPTURE}
//   address base/offset localparams
//   STATUS/CTRL bit indices
//   DIM and NWORDS constants
//  Sub-module mm_word_buf: 64x32 register buffer with synchronous reset, write port,
//   async read port and full-array output. Instantiated for A, B and C.
//  The matrix_mul datapath is instantiated by the parent, not inside this block.
// TESTING
//  Identity: A=I, B[k]=k+1, GO, poll STATUS -> done=1, busy=0, C[k]=k+1 for k=0..63,
//   irq=1 if irq_en=1.
//  Constant: A all 2, B all 3, GO -> every C word = 48. Measured latency matches the formula.
//  Timeout: mm_done tied 0, GO -> after 64 RUN cycles STATUS=0x4, mm_start=0, C unchanged.
//  Busy protection: write A[0]=0xDEAD during RUN -> wr_err=1, A[0] unchanged.
//   GO during RUN -> no restart.
//  W1C/priority: write STATUS=0xE in the CAPTURE cycle -> done=1; next W1C -> STATUS=0.
//  Reset mid-RUN then new GO: FSM goes IDLE, mm_start=0, C buffer=0.
//   The second run gives correct C, with mm_clear pulsed once per run.

Source files
------------

// File: rtl/matrix_mul_ctrl_pkg.sv
// Shared types and constants for the matrix_mul sequencer: FSM states, the host
// address map, register bit positions and buffer geometry.
package matrix_mul_ctrl_pkg;

  localparam int DIM    = 8;
  localparam int NWORDS = DIM * DIM;
  localparam int DW     = 32;
  localparam int AW     = 10;
  localparam int IDXW   = $clog2(NWORDS);

  localparam logic [AW-1:0] A_BASE      = 10'h000;
  localparam logic [AW-1:0] B_BASE      = 10'h100;
  localparam logic [AW-1:0] C_BASE      = 10'h200;
  localparam logic [AW-1:0] CTRL_ADDR   = 10'h300;
  localparam logic [AW-1:0] STATUS_ADDR = 10'h304;

  localparam logic [AW-3:0] CTRL_WORD   = CTRL_ADDR[AW-1:2];
  localparam logic [AW-3:0] STATUS_WORD = STATUS_ADDR[AW-1:2];

  localparam int CTRL_GO     = 0;
  localparam int CTRL_IRQ_EN = 1;

  localparam int ST_BUSY    = 0;
  localparam int ST_DONE    = 1;
  localparam int ST_TIMEOUT = 2;
  localparam int ST_WR_ERR  = 3;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    RUN,
    DRAIN,
    CAPTURE
  } state_e;

  typedef enum logic [2:0] {
    SEL_A,
    SEL_B,
    SEL_C,
    SEL_CTRL,
    SEL_STATUS,
    SEL_NONE
  } sel_e;

  // Word address (byte address without bits [1:0]) to target region.
  function automatic sel_e decodeAddr(input logic [AW-3:0] wordAddr);
    sel_e sel;
    case (wordAddr[AW-3:AW-4])
      2'd0:    sel = SEL_A;
      2'd1:    sel = SEL_B;
      2'd2:    sel = SEL_C;
      default: begin
        if (wordAddr == CTRL_WORD) begin
          sel = SEL_CTRL;
        end else if (wordAddr == STATUS_WORD) begin
          sel = SEL_STATUS;
        end else begin
          sel = SEL_NONE;
        end
      end
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/mm_word_buf.sv
// NWORDS x DW register buffer: one word write port, a whole-array load port,
// an asynchronous word read port and the full array as a flat output.
module mm_word_buf
  import matrix_mul_ctrl_pkg::*;
(
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         we_i,
  input  logic [IDXW-1:0]              waddr_i,
  input  logic [DW-1:0]                wdata_i,
  input  logic                         load_i,
  input  logic [NWORDS-1:0][DW-1:0]    ldata_i,
  input  logic [IDXW-1:0]              raddr_i,
  output logic [DW-1:0]                rdata_o,
  output logic [NWORDS-1:0][DW-1:0]    mem_o
);

  logic [NWORDS-1:0][DW-1:0] mem_q;

  // A bulk load takes priority over a single-word write.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q <= '0;
    end else if (load_i) begin
      mem_q <= ldata_i;
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];
  assign mem_o   = mem_q;

endmodule

// File: rtl/matrix_mul_ctrl.sv
// Host-programmable sequencer for the 8x8 matrix_mul datapath: operand buffers,
// clear/run/drain/capture FSM, result buffer and sticky status reporting.
module matrix_mul_ctrl
  import matrix_mul_ctrl_pkg::*;
#(
  parameter int DRAIN_CYCLES = 2,
  parameter int TIMEOUT      = 64
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         host_req,
  input  logic                         host_we,
  input  logic [AW-1:0]                host_addr,
  input  logic [DW-1:0]                host_wdata,
  output logic                         host_ack,
  output logic [DW-1:0]                host_rdata,
  output logic                         irq,
  output logic [NWORDS-1:0][DW-1:0]    mm_A,
  output logic [NWORDS-1:0][DW-1:0]    mm_B,
  input  logic [NWORDS-1:0][DW-1:0]    mm_C,
  output logic                         mm_start,
  output logic                         mm_clear,
  input  logic                         mm_done
);

  localparam int RCW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int DCW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  state_e           state_q, state_d;
  logic [RCW-1:0]   runCnt_q, runCnt_d;
  logic [DCW-1:0]   drainCnt_q, drainCnt_d;
  logic             done_q, done_d;
  logic             timeout_q, timeout_d;
  logic             wrErr_q, wrErr_d;
  logic             irqEn_q, irqEn_d;
  logic             ack_q;
  logic [DW-1:0]    rdata_q, rdata_d;

  sel_e             hostSel;
  logic [IDXW-1:0]  wordIdx;
  logic [1:0]       unusedAddrBits;
  logic             busy;
  logic             hostWr;
  logic             wrA, wrB;
  logic             ctrlWr, goStart, statusWr, badWrite;
  logic             capture, timeoutSet;
  logic [DW-1:0]    aRd, bRd, cRd;
  logic [DW-1:0]    statusWord, ctrlWord;
  logic [NWORDS-1:0][DW-1:0] unusedCArray;

  assign hostSel        = decodeAddr(host_addr[AW-1:2]);
  assign wordIdx        = host_addr[IDXW+1:2];
  assign unusedAddrBits = host_addr[1:0];
  assign busy           = (state_q != IDLE);
  assign hostWr         = host_req && host_we;

  // Operand buffers are frozen while busy so mm_A/mm_B stay stable for the datapath.
  assign wrA      = hostWr && (hostSel == SEL_A) && !busy;
  assign wrB      = hostWr && (hostSel == SEL_B) && !busy;
  assign ctrlWr   = hostWr && (hostSel == SEL_CTRL);
  assign goStart  = ctrlWr && host_wdata[CTRL_GO] && !busy;
  assign statusWr = hostWr && (hostSel == SEL_STATUS);
  assign badWrite = hostWr && ((hostSel == SEL_NONE) || (hostSel == SEL_C) ||
                               (((hostSel == SEL_A) || (hostSel == SEL_B)) && busy));

  mm_word_buf uBufA (
    .clk     (clk),
    .reset   (reset),
    .we_i    (wrA),
    .waddr_i (wordIdx),
    .wdata_i (host_wdata),
    .load_i  (1'b0),
    .ldata_i ('0),
    .raddr_i (wordIdx),
    .rdata_o (aRd),
    .mem_o   (mm_A)
  );

  mm_word_buf uBufB (
    .clk     (clk),
    .reset   (reset),
    .we_i    (wrB),
    .waddr_i (wordIdx),
    .wdata_i (host_wdata),
    .load_i  (1'b0),
    .ldata_i ('0),
    .raddr_i (wordIdx),
    .rdata_o (bRd),
    .mem_o   (mm_B)
  );

  // Result buffer is only ever loaded as a whole in the CAPTURE cycle.
  mm_word_buf uBufC (
    .clk     (clk),
    .reset   (reset),
    .we_i    (1'b0),
    .waddr_i ('0),
    .wdata_i ('0),
    .load_i  (capture),
    .ldata_i (mm_C),
    .raddr_i (wordIdx),
    .rdata_o (cRd),
    .mem_o   (unusedCArray)
  );

  always_comb begin
    state_d    = state_q;
    runCnt_d   = runCnt_q;
    drainCnt_d = drainCnt_q;
    mm_start   = 1'b0;
    mm_clear   = 1'b0;
    capture    = 1'b0;
    timeoutSet = 1'b0;
    case (state_q)
      IDLE: begin
        if (goStart) begin
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        mm_clear = 1'b1;
        runCnt_d = '0;
        state_d  = RUN;
      end
      RUN: begin
        mm_start = 1'b1;
        if (mm_done) begin
          drainCnt_d = '0;
          state_d    = DRAIN;
        end else if (runCnt_q == RCW'(TIMEOUT - 1)) begin
          timeoutSet = 1'b1;
          state_d    = IDLE;
        end else begin
          runCnt_d = runCnt_q + 1'b1;
        end
      end
      DRAIN: begin
        mm_start = 1'b1;
        if (drainCnt_q == DCW'(DRAIN_CYCLES - 1)) begin
          state_d = CAPTURE;
        end else begin
          drainCnt_d = drainCnt_q + 1'b1;
        end
      end
      CAPTURE: begin
        capture = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Hardware set events are applied last so they win over a same-cycle W1C.
  always_comb begin
    done_d    = done_q;
    timeout_d = timeout_q;
    wrErr_d   = wrErr_q;
    irqEn_d   = irqEn_q;
    if (statusWr) begin
      if (host_wdata[ST_DONE])    done_d    = 1'b0;
      if (host_wdata[ST_TIMEOUT]) timeout_d = 1'b0;
      if (host_wdata[ST_WR_ERR])  wrErr_d   = 1'b0;
    end
    if (ctrlWr) begin
      irqEn_d = host_wdata[CTRL_IRQ_EN];
    end
    if (goStart) begin
      done_d    = 1'b0;
      timeout_d = 1'b0;
    end
    if (badWrite)   wrErr_d   = 1'b1;
    if (capture)    done_d    = 1'b1;
    if (timeoutSet) timeout_d = 1'b1;
  end

  always_comb begin
    statusWord             = '0;
    statusWord[ST_BUSY]    = busy;
    statusWord[ST_DONE]    = done_q;
    statusWord[ST_TIMEOUT] = timeout_q;
    statusWord[ST_WR_ERR]  = wrErr_q;
    ctrlWord               = '0;
    ctrlWord[CTRL_IRQ_EN]  = irqEn_q;
  end

  always_comb begin
    rdata_d = '0;
    if (host_req && !host_we) begin
      case (hostSel)
        SEL_A:      rdata_d = aRd;
        SEL_B:      rdata_d = bRd;
        SEL_C:      rdata_d = cRd;
        SEL_CTRL:   rdata_d = ctrlWord;
        SEL_STATUS: rdata_d = statusWord;
        default:    rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      runCnt_q   <= '0;
      drainCnt_q <= '0;
      done_q     <= 1'b0;
      timeout_q  <= 1'b0;
      wrErr_q    <= 1'b0;
      irqEn_q    <= 1'b0;
      ack_q      <= 1'b0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      runCnt_q   <= runCnt_d;
      drainCnt_q <= drainCnt_d;
      done_q     <= done_d;
      timeout_q  <= timeout_d;
      wrErr_q    <= wrErr_d;
      irqEn_q    <= irqEn_d;
      ack_q      <= host_req;
      rdata_q    <= rdata_d;
    end
  end

  assign host_ack   = ack_q;
  assign host_rdata = rdata_q;
  assign irq        = done_q && irqEn_q;

endmodule

// File: tb/tb_matrix_mul_ctrl.sv
// Scoreboard bench for matrix_mul_ctrl with a behavioural matrix_mul datapath model.
module tb_matrix_mul_ctrl;
  import matrix_mul_ctrl_pkg::*;

  localparam int DRAIN = 2;
  localparam int TMO   = 64;

  logic                      clk = 1'b0;
  logic                      reset = 1'b1;
  logic                      host_req = 1'b0;
  logic                      host_we = 1'b0;
  logic [9:0]                host_addr = '0;
  logic [31:0]               host_wdata = '0;
  logic                      host_ack;
  logic [31:0]               host_rdata;
  logic                      irq;
  logic [NWORDS-1:0][31:0]   mm_A, mm_B, mm_C;
  logic                      mm_start, mm_clear, mm_done;

  matrix_mul_ctrl #(.DRAIN_CYCLES(DRAIN), .TIMEOUT(TMO)) dut (
    .clk        (clk),
    .reset      (reset),
    .host_req   (host_req),
    .host_we    (host_we),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .host_ack   (host_ack),
    .host_rdata (host_rdata),
    .irq        (irq),
    .mm_A       (mm_A),
    .mm_B       (mm_B),
    .mm_C       (mm_C),
    .mm_start   (mm_start),
    .mm_clear   (mm_clear),
    .mm_done    (mm_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Datapath model: counts start cycles since the last clear, raises done after
  // dpLat of them and only presents the product once the drain period is over.
  int  dpLat = 5;
  bit  dpNeverDone = 1'b0;
  int  dpCnt = 0;
  int  clearCount = 0;
  logic [NWORDS-1:0][31:0] prod;
  logic [31:0] acc;

  always @(posedge clk) begin
    if (mm_clear) begin
      dpCnt      <= 0;
      clearCount <= clearCount + 1;
    end else if (mm_start) begin
      dpCnt <= dpCnt + 1;
    end
  end

  assign mm_done = !dpNeverDone && (dpCnt >= dpLat);

  always_comb begin
    prod = '0;
    acc  = '0;
    for (int i = 0; i < DIM; i++) begin
      for (int j = 0; j < DIM; j++) begin
        acc = '0;
        for (int k = 0; k < DIM; k++) begin
          acc = acc + mm_A[i*DIM+k] * mm_B[k*DIM+j];
        end
        prod[i*DIM+j] = acc;
      end
    end
  end

  assign mm_C = (dpCnt >= dpLat + DRAIN) ? prod : '0;

  typedef struct {
    bit          isRead;
    logic [31:0] exp;
    int          issue;
    string       name;
  } sbItem_t;

  sbItem_t sbq[$];
  sbItem_t monItem;
  int compared = 0;
  int mismatched = 0;
  int lastIssue = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every ack pops the oldest outstanding access; an access left
  // unacknowledged for more than one cycle is reported as missing.
  always @(negedge clk) begin
    if (host_ack) begin
      if (sbq.size() == 0) begin
        checkOutput("spurious_ack", 32'(1), 32'(0));
      end else begin
        monItem = sbq.pop_front();
        checkOutput({monItem.name, "_acklat"}, 32'(cyc - monItem.issue), 32'(1));
        if (monItem.isRead) checkOutput(monItem.name, host_rdata, monItem.exp);
      end
    end else if (sbq.size() > 0 && (cyc - sbq[0].issue) > 1) begin
      monItem = sbq.pop_front();
      checkOutput({monItem.name, "_noack"}, 32'(0), 32'(1));
    end
  end

  task automatic applyStimulus(input bit we, input logic [9:0] addr, input logic [31:0] data,
                               input logic [31:0] exp, input string name);
    sbItem_t it;
    @(negedge clk);
    host_req   = 1'b1;
    host_we    = we;
    host_addr  = addr;
    host_wdata = data;
    it.isRead  = !we;
    it.exp     = exp;
    it.issue   = cyc;
    it.name    = name;
    sbq.push_back(it);
    lastIssue  = cyc;
  endtask

  task automatic wr(input logic [9:0] addr, input logic [31:0] data, input string name);
    applyStimulus(1'b1, addr, data, '0, name);
  endtask

  task automatic rd(input logic [9:0] addr, input logic [31:0] exp, input string name);
    applyStimulus(1'b0, addr, '0, exp, name);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      host_req = 1'b0;
    end
  endtask

  task automatic waitSbEmpty();
    int guard = 0;
    idle(1);
    while (sbq.size() > 0 && guard < 20) begin
      idle(1);
      guard++;
    end
    if (sbq.size() > 0) checkOutput("sb_drain", 32'(sbq.size()), 32'(0));
  endtask

  // Cycles from the GO acknowledge to irq rising, bounded.
  task automatic waitIrq(input int goIssue, input int expLat, input string name);
    int n = 0;
    do begin
      idle(1);
      n++;
    end while (!irq && n < 300);
    if (!irq) checkOutput({name, "_irq_wait"}, 32'(0), 32'(1));
    else      checkOutput({name, "_latency"}, 32'(cyc - goIssue - 1), 32'(expLat));
  endtask

  int goIssue;
  int clr0;
  int hi;
  int n;
  bit seen;

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    checkOutput("rst_ack", 32'(host_ack), 32'(0));
    checkOutput("rst_irq", 32'(irq), 32'(0));
    checkOutput("rst_start", 32'(mm_start), 32'(0));
    checkOutput("rst_clear", 32'(mm_clear), 32'(0));
    reset = 1'b0;
    rd(10'h304, 32'h0, "rst_status");
    rd(10'h300, 32'h0, "rst_ctrl");
    rd(10'h000, 32'h0, "rst_A0");
    rd(10'h214, 32'h0, "rst_C5");

    // Unmapped access and W1C of wr_err
    wr(10'h308, 32'h1234, "wr_unmapped");
    rd(10'h308, 32'h0, "rd_unmapped");
    rd(10'h3FC, 32'h0, "rd_unmapped_top");
    rd(10'h304, 32'h8, "status_wrerr");
    wr(10'h304, 32'h8, "w1c_wrerr");
    rd(10'h304, 32'h0, "status_cleared");

    // Identity: A = I, B[k] = k+1
    for (int i = 0; i < DIM; i++) wr(10'(i * (DIM + 1) * 4), 32'd1, "wrA_diag");
    for (int k = 0; k < NWORDS; k++) wr(10'h100 + 10'(k * 4), 32'(k + 1), "wrB");
    wr(10'h300, 32'h2, "ctrl_irqen");
    rd(10'h300, 32'h2, "ctrl_rb");
    rd(10'h024, 32'h1, "A9_rb");
    rd(10'h1FC, 32'd64, "B63_rb");
    dpLat = 5;
    clr0 = clearCount;
    wr(10'h300, 32'h3, "go_identity");
    goIssue = lastIssue;
    waitIrq(goIssue, dpLat + 5, "identity");
    checkOutput("identity_clears", 32'(clearCount - clr0), 32'(1));
    checkOutput("identity_start_idle", 32'(mm_start), 32'(0));
    rd(10'h304, 32'h2, "identity_status");
    rd(10'h300, 32'h2, "identity_ctrl_go_reads0");
    for (int k = 0; k < NWORDS; k++) rd(10'h200 + 10'(k * 4), 32'(k + 1), $sformatf("idC[%0d]", k));
    wr(10'h304, 32'h2, "w1c_done");
    idle(2);
    checkOutput("irq_after_w1c", 32'(irq), 32'(0));
    rd(10'h304, 32'h0, "status_after_w1c");

    // Constant: A all 2, B all 3 -> 48 everywhere
    for (int k = 0; k < NWORDS; k++) wr(10'h000 + 10'(k * 4), 32'd2, "wrA2");
    for (int k = 0; k < NWORDS; k++) wr(10'h100 + 10'(k * 4), 32'd3, "wrB3");
    dpLat = 3;
    clr0 = clearCount;
    wr(10'h300, 32'h3, "go_const");
    goIssue = lastIssue;
    waitIrq(goIssue, dpLat + 5, "const");
    checkOutput("const_clears", 32'(clearCount - clr0), 32'(1));
    for (int k = 0; k < NWORDS; k++) rd(10'h200 + 10'(k * 4), 32'd48, $sformatf("cstC[%0d]", k));

    // Busy protection, C reads of the previous capture, GO ignored while busy
    dpLat = 20;
    clr0 = clearCount;
    wr(10'h300, 32'h3, "go_busy");
    goIssue = lastIssue;
    idle(3);
    wr(10'h000, 32'hDEAD, "wrA0_busy");
    rd(10'h204, 32'd48, "busy_C1_prev");
    wr(10'h300, 32'h3, "go_during_run");
    waitIrq(goIssue, dpLat + 5, "busy");
    checkOutput("busy_clears", 32'(clearCount - clr0), 32'(1));
    rd(10'h304, 32'hA, "busy_status");
    rd(10'h000, 32'd2, "busy_A0_kept");
    rd(10'h2FC, 32'd48, "busy_C63");
    wr(10'h304, 32'hA, "w1c_busy");
    rd(10'h304, 32'h0, "busy_status_cleared");

    // W1C in the CAPTURE cycle: the set wins
    dpLat = 3;
    wr(10'h300, 32'h3, "go_w1c");
    idle(dpLat + 4);
    wr(10'h304, 32'hE, "w1c_in_capture");
    rd(10'h304, 32'h2, "capture_set_wins");
    wr(10'h304, 32'hE, "w1c_again");
    rd(10'h304, 32'h0, "status_zero");

    // Timeout: datapath never signals done
    dpNeverDone = 1'b1;
    wr(10'h300, 32'h3, "go_timeout");
    hi = 0;
    n = 0;
    seen = 1'b0;
    do begin
      idle(1);
      n++;
      if (mm_start) begin
        hi++;
        seen = 1'b1;
      end
    end while (!(seen && !mm_start) && n < 300);
    checkOutput("tmo_start_cycles", 32'(hi), 32'(TMO));
    checkOutput("tmo_start_low", 32'(mm_start), 32'(0));
    rd(10'h304, 32'h4, "tmo_status");
    rd(10'h20C, 32'd48, "tmo_C3_kept");
    idle(1);
    checkOutput("tmo_irq", 32'(irq), 32'(0));
    wr(10'h304, 32'h4, "w1c_tmo");
    rd(10'h304, 32'h0, "tmo_status_cleared");
    dpNeverDone = 1'b0;

    // Reset in the middle of RUN, then a fresh run
    dpLat = 10;
    wr(10'h300, 32'h3, "go_pre_reset");
    idle(5);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("midrst_start", 32'(mm_start), 32'(0));
    rd(10'h304, 32'h0, "midrst_status");
    rd(10'h300, 32'h0, "midrst_ctrl");
    rd(10'h200, 32'h0, "midrst_C0");
    rd(10'h2A0, 32'h0, "midrst_C40");
    rd(10'h000, 32'h0, "midrst_A0");
    for (int i = 0; i < DIM; i++) wr(10'(i * (DIM + 1) * 4), 32'd1, "wrA_diag2");
    for (int k = 0; k < NWORDS; k++) wr(10'h100 + 10'(k * 4), 32'(64 - k), "wrB2");
    clr0 = clearCount;
    wr(10'h300, 32'h3, "go_after_reset");
    goIssue = lastIssue;
    waitIrq(goIssue, dpLat + 5, "rerun");
    checkOutput("rerun_clears", 32'(clearCount - clr0), 32'(1));
    for (int k = 0; k < NWORDS; k++) rd(10'h200 + 10'(k * 4), 32'(64 - k), $sformatf("rrC[%0d]", k));
    rd(10'h304, 32'h2, "rerun_status");

    waitSbEmpty();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
